// File: rtl/alu_pkg.sv
// Shared types and constants for the 1-bit ALU checkers.
// Op encodings match the ALU slice's op select.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  localparam int NUM_VECTORS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } chk_state_e;

endpackage

// File: rtl/alu1_golden_model.sv
// Combinational reference for the 1-bit ALU slice.
// Gives expected outputs plus per-op compare enables.
module alu1_golden_model
  import alu_pkg::*;
#(
  parameter bit CHECK_OP3 = 1'b0
) (
  input  logic       in1,
  input  logic       in2,
  input  logic       carry_in,
  input  logic [1:0] op,
  output logic       exp_result,
  output logic       exp_carry,
  output logic       chk_result,
  output logic       chk_carry
);

  logic [1:0] sum;

  always_comb begin
    sum = {1'b0, in1} + {1'b0, in2} + {1'b0, carry_in};
    exp_result = 1'b0;
    exp_carry  = 1'b0;
    chk_result = 1'b1;
    chk_carry  = 1'b0;
    unique case (op)
      OP_AND: exp_result = in1 & in2;
      OP_OR:  exp_result = in1 | in2;
      OP_ADD: begin
        exp_result = sum[0];
        exp_carry  = sum[1];
        chk_carry  = 1'b1;
      end
      OP_XOR: begin
        exp_result = in1 ^ in2;
        chk_result = CHECK_OP3;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu1_vector_checker.sv
// Self-test sweep engine for one 1-bit ALU slice.
// Applies all 32 vectors and tallies mismatches.
module alu1_vector_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit CHECK_OP3     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       alu_carry_out,
  input  logic       alu_result,
  output logic       alu_in1,
  output logic       alu_in2,
  output logic       alu_carry_in,
  output logic [1:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       first_fail_valid,
  output logic [4:0] first_fail_idx
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 1) ? 4'(SETTLE_CYCLES - 2) : 4'd0;

  chk_state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [4:0] ffi_q, ffi_d;

  logic exp_result, exp_carry;
  logic chk_result, chk_carry;
  logic mismatch;

  alu1_golden_model #(
    .CHECK_OP3(CHECK_OP3)
  ) u_golden (
    .in1       (vec_q[2]),
    .in2       (vec_q[1]),
    .carry_in  (vec_q[0]),
    .op        (vec_q[4:3]),
    .exp_result(exp_result),
    .exp_carry (exp_carry),
    .chk_result(chk_result),
    .chk_carry (chk_carry)
  );

  assign mismatch =
    (chk_result && (alu_result != exp_result)) ||
    (chk_carry && (alu_carry_out != exp_carry));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 5'd0;
          err_d   = 6'd0;
          ffv_d   = 1'b0;
          ffi_d   = 5'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        vec_d   = idx_q;
        cnt_d   = 4'd0;
        state_d = (SETTLE_CYCLES > 1) ? S_SETTLE : S_CHECK;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 6'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == 6'd0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
    end
  end

  assign alu_op           = vec_q[4:3];
  assign alu_in1          = vec_q[2];
  assign alu_in2          = vec_q[1];
  assign alu_carry_in     = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: doc/alu1_vector_checker.md
Name: alu1_vector_checker

Overview:
- Synthesizable self-test engine for the 1-bit ALU slice (`my1BitALU`).
- On `start`, it drives all 32 combinations of in1, in2, carryIn and op into the ALU under test.
- It samples carryOut and result after a programmable settle time and compares them against an internal golden model.
- It reports pass/fail, the error count and the first failing vector. It sits beside each ALU slice as its built-in response-side checker.

Parameters:
- SETTLE_CYCLES, 1, clock cycles between applying a vector and sampling the ALU outputs; legal range 1..15.
- CHECK_OP3, 0, 1 = compare op 3 vectors against the XOR golden model; 0 = apply op 3 vectors but never flag them.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  run request, sampled only in IDLE
- alu_carry_out  input  1  carryOut from the ALU under test
- alu_result  input  1  result from the ALU under test
- alu_in1  output  1  ALU operand A
- alu_in2  output  1  ALU operand B
- alu_carry_in  output  1  ALU carry in
- alu_op  output  2  ALU operation select
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  1 if the last completed sweep had zero errors
- err_count  output  6  mismatches in the last/current sweep (0..32)
- first_fail_valid  output  1  at least one mismatch has been recorded
- first_fail_idx  output  5  vector index of the first mismatch

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - All outputs are 0, including the driven ALU inputs; pass = 0 and err_count = 0.
- Reset asserted mid-sweep aborts immediately. No done pulse is issued and the partial results are discarded.
- Vector index idx[4:0] maps to the ALU inputs as: alu_op = idx[4:3], alu_in1 = idx[2], alu_in2 = idx[1], alu_carry_in = idx[0]. The sweep order is idx 0..31.
- Golden model, where s = in1 + in2 + cin:
  - op 0: result = in1 & in2.
  - op 1: result = in1 | in2.
  - op 2: result = s[0] and carryOut = s[1].
  - op 3: result = in1 ^ in2.
  - carryOut is compared only for op 2; for other ops it is don't-care.
  - op 3 vectors are compared only when CHECK_OP3 = 1.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE & start=1: idx=0; err_count, first_fail_valid and first_fail_idx are cleared; pass=0; busy=1; go to APPLY.
  - APPLY: the registered ALU inputs take the value of idx; go to SETTLE with the wait counter at 0.
  - SETTLE: the wait counter increments each cycle; after SETTLE_CYCLES-1 further cycles, go to CHECK. With SETTLE_CYCLES=1 the path is APPLY→CHECK directly.
  - CHECK: the ALU outputs are sampled and compared.
    - On a mismatch, err_count increments. If first_fail_valid=0, first_fail_idx=idx and first_fail_valid=1.
    - If idx=31, go to DONE; otherwise idx increments and the FSM goes to APPLY.
  - DONE: done=1 for one cycle; pass = (err_count==0) after the last compare; busy=0; go to IDLE.
- Timing:
  - Each vector occupies exactly SETTLE_CYCLES+1 cycles.
  - done pulses in cycle 32*(SETTLE_CYCLES+1)+1 after start is accepted. That is 65 cycles at the default; 129 at SETTLE_CYCLES=3.
- The ALU inputs hold the last applied vector (idx 31) after DONE until the next start.
- start while busy is ignored, with no restart and no queuing. start held high continuously re-launches a sweep on the cycle after DONE.
- pass, err_count and first_fail_* hold their values after DONE until the next accepted start.
- err_count cannot overflow: the maximum is 32, which fits in 6 bits.

Decomposition:
- Shared package `alu_pkg`:
  - op encoding constants: OP_AND=2'd0, OP_OR=2'd1, OP_ADD=2'd2, OP_XOR=2'd3;
  - the FSM state typedef;
  - the vector-count constant NUM_VECTORS=32.
- One sub-module, `alu1_golden_model`: a combinational reference giving the expected result, the expected carry and a compare-enable mask per op. It is reusable by later multi-bit ALU checkers.

Test Plan:
- Correct ALU model, SETTLE_CYCLES=1, start pulse → busy for 64 cycles, done pulse at cycle 65, pass=1, err_count=0, first_fail_valid=0.
- Faulty ALU with result stuck-at-0 for op 1 → err_count=6, first_fail_idx=10, pass=0.
- Faulty ALU with inverted carryOut for op 2 → err_count=8, first_fail_idx=16. Inverting carryOut for ops 0/1/3 only → pass=1.
- ALU returning inverted XOR for op 3:
  - CHECK_OP3=0 → pass=1.
  - CHECK_OP3=1 → err_count=8, first_fail_idx=24.
- SETTLE_CYCLES=3, correct ALU, plus extra start pulses at cycles 10 and 50 → single sweep, done at cycle 129, pass=1.
- rst_n dropped at cycle 20 of a sweep, then start → all outputs 0 immediately with no done pulse; the fresh sweep completes normally with err_count counted from 0.
